rtc_rd_chan_ctrl: RTL

Parametrised, registered read channel for the CAN controller Microcontroller Interface. It accepts single-cycle read requests and decodes the address against the controller register map into a one-hot register-select vector. It waits for the register-file acknowledge, optionally bounded by a timeout, and returns captured data with completion and error pulses. It sits between `rtc_mc_if` and the register file.

---
 rtl/rtc_mc_pkg.sv | 21 ++
 rtl/rtc_rd_addr_dec.sv | 30 +++
 rtl/rtc_rd_chan_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/rtc_mc_pkg.sv
// rtl/rtc_mc_pkg.sv - shared types and register-map constants for the MC interface read channel
package rtc_mc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } rd_state_t;

    localparam int unsigned RD_LO_BASE = 32'h00;
    localparam int unsigned RD_LO_LAST = 32'h08;
    localparam int unsigned RD_HI_BASE = 32'h14;
    localparam int unsigned RD_HI_LAST = 32'h20;
    localparam int unsigned RD_HI_BIT  = 18;

    // Offset-from-base compares stay correct even when a base is zero.
    function automatic logic rd_addr_valid(input logic [31:0] addr);
        return ((addr - RD_LO_BASE) <= (RD_LO_LAST - RD_LO_BASE)) ||
               ((addr - RD_HI_BASE) <= (RD_HI_LAST - RD_HI_BASE));
    endfunction

endpackage

// File: rtl/rtc_rd_addr_dec.sv
// rtl/rtc_rd_addr_dec.sv - combinational read address to {valid, one-hot select} decoder
module rtc_rd_addr_dec
    import rtc_mc_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int SEL_W  = 31
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic [SEL_W-1:0]  sel
);

    logic [31:0] addr_w;
    logic [31:0] bit_idx;

    always_comb begin
        addr_w  = 32'(addr);
        valid   = rd_addr_valid(addr_w);
        sel     = '0;
        if (addr_w <= RD_LO_LAST) begin
            bit_idx = addr_w - RD_LO_BASE;
        end else begin
            bit_idx = addr_w - RD_HI_BASE + RD_HI_BIT;
        end
        if (valid && (bit_idx < 32'(SEL_W))) begin
            sel = SEL_W'(1) << bit_idx;
        end
    end

endmodule

// File: rtl/rtc_rd_chan_ctrl.sv
// rtl/rtc_rd_chan_ctrl.sv - registered read channel FSM; RTC_RD_TIMEOUT_EN adds the ack timeout abort
module rtc_rd_chan_ctrl
    import rtc_mc_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 31,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_reg_r_data,
    input  logic              i_ack,
    output logic [SEL_W-1:0]  o_rd_sel,
    output logic [DATA_W-1:0] o_reg_data,
    output logic              o_rd_valid,
    output logic              o_rd_err,
    output logic              o_busy
);

    rd_state_t         state, state_n;
    logic              dec_valid;
    logic [SEL_W-1:0]  dec_sel;
    logic [SEL_W-1:0]  sel_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;
    logic              err_n;

    rtc_rd_addr_dec #(
        .ADDR_W(ADDR_W),
        .SEL_W (SEL_W)
    ) u_dec (
        .addr (i_addr),
        .valid(dec_valid),
        .sel  (dec_sel)
    );

`ifdef RTC_RD_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
    logic [7:0] cnt, cnt_n;
`endif

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= IDLE;
            o_rd_sel   <= '0;
            o_reg_data <= '0;
            o_rd_valid <= 1'b0;
            o_rd_err   <= 1'b0;
`ifdef RTC_RD_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_n;
            o_rd_sel   <= sel_n;
            o_reg_data <= data_n;
            o_rd_valid <= valid_n;
            o_rd_err   <= err_n;
`ifdef RTC_RD_TIMEOUT_EN
            cnt        <= cnt_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = o_rd_sel;
        data_n  = o_reg_data;
        valid_n = 1'b0;
        err_n   = 1'b0;
`ifdef RTC_RD_TIMEOUT_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE: begin
                if (i_rd_en) begin
                    if (dec_valid) begin
                        sel_n   = dec_sel;
                        state_n = WAIT;
`ifdef RTC_RD_TIMEOUT_EN
                        cnt_n   = '0;
`endif
                    end else begin
                        err_n  = 1'b1;
                        data_n = '0;
                    end
                end
            end
            WAIT: begin
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (i_ack) begin
                    data_n  = i_reg_r_data;
                    valid_n = 1'b1;
                    sel_n   = '0;
                    state_n = IDLE;
                end
`ifdef RTC_RD_TIMEOUT_EN
                else if (cnt == TMO_LAST) begin
                    err_n   = 1'b1;
                    data_n  = '0;
                    sel_n   = '0;
                    state_n = IDLE;
                end else if (cnt != 8'hFF) begin
                    cnt_n = cnt + 8'd1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_busy = (state == WAIT);

endmodule
